// File: rtl/cfg_chain_loader.sv
// Loads a PE block's serial configuration chain from a word stream: clears the
// chain, then shifts CHAIN_LEN bits LSB-first on a generated, registered config_clk.
module cfg_chain_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 64,
  parameter int RST_CYC   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              busy,
  output logic              done,
  output logic              config_clk,
  output logic              config_reset,
  output logic              config_in
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int CLR_W = $clog2(RST_CYC + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(RST_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FETCH,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              phase_b_q, phase_b_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CLR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cclk_q, cclk_d;
  logic              crst_q, crst_d;
  logic              cin_q, cin_d;

  logic [IDX_W-1:0]  idx_nxt;

  assign idx_nxt = idx_q + IDX_W'(1);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    phase_b_d = phase_b_q;
    bit_cnt_d = bit_cnt_q;
    idx_d     = idx_q;
    clr_cnt_d = clr_cnt_q;
    word_d    = word_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cclk_d    = cclk_q;
    crst_d    = crst_q;
    cin_d     = cin_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CLR;
          busy_d    = 1'b1;
          crst_d    = 1'b1;
          clr_cnt_d = '0;
          bit_cnt_d = '0;
          cclk_d    = 1'b0;
          cin_d     = 1'b0;
        end
      end

      S_CLR: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (clr_cnt_q == CLR_LAST) begin
          state_d = S_FETCH;
          crst_d  = 1'b0;
          ready_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + CLR_W'(1);
        end
      end

      S_FETCH: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (word_valid && ready_q) begin
          state_d   = S_SHIFT;
          word_d    = word_in;
          idx_d     = '0;
          phase_b_d = 1'b0;
          ready_d   = 1'b0;
          cclk_d    = 1'b0;
          cin_d     = word_in[0];
        end
      end

      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (!phase_b_q) begin
          cclk_d    = 1'b1;
          phase_b_d = 1'b1;
        end else begin
          // The falling edge of config_clk is where data may change for the next bit.
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          cclk_d    = 1'b0;
          phase_b_d = 1'b0;
          if (bit_cnt_q == CNT_LAST) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else if (idx_q == IDX_LAST) begin
            state_d = S_FETCH;
            ready_d = 1'b1;
          end else begin
            idx_d = idx_nxt;
            cin_d = word_q[idx_nxt];
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        cclk_d  = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase

    // Abort from any active state drops every chain-facing output at once.
    if (abort && (state_q == S_CLR || state_q == S_FETCH || state_q == S_SHIFT)) begin
      ready_d   = 1'b0;
      busy_d    = 1'b0;
      cclk_d    = 1'b0;
      crst_d    = 1'b0;
      cin_d     = 1'b0;
      phase_b_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= S_IDLE;
      phase_b_q <= 1'b0;
      bit_cnt_q <= '0;
      idx_q     <= '0;
      clr_cnt_q <= '0;
      // NOTE: the word register needs no reset functionally (it is always
      // loaded before use); it is cleared anyway so outputs never see X.
      word_q    <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cclk_q    <= 1'b0;
      crst_q    <= 1'b0;
      cin_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_b_q <= phase_b_d;
      bit_cnt_q <= bit_cnt_d;
      idx_q     <= idx_d;
      clr_cnt_q <= clr_cnt_d;
      word_q    <= word_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cclk_q    <= cclk_d;
      crst_q    <= crst_d;
      cin_q     <= cin_d;
    end
  end

  assign word_ready   = ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign config_clk   = cclk_q;
  assign config_reset = crst_q;
  assign config_in    = cin_q;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Self-checking bench for cfg_chain_loader: three instances (CHAIN_LEN 37, 64, 32)
// share stimulus through a selector; a chain-capture model checks every load.
module tb_cfg_chain_loader;

  localparam int W   = 32;
  localparam int RST = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, start, abort, word_valid;
  logic [W-1:0] word_in;
  logic [1:0]   sel;

  logic [2:0] start_v, abort_v, valid_v;
  logic [2:0] ready_v, busy_v, done_v, cclk_v, crst_v, cin_v;
  logic       m_ready, m_busy, m_done, m_cclk, m_crst, m_cin;

  always_comb begin
    start_v = '0;
    abort_v = '0;
    valid_v = '0;
    start_v[sel] = start;
    abort_v[sel] = abort;
    valid_v[sel] = word_valid;
    m_ready = ready_v[sel];
    m_busy  = busy_v[sel];
    m_done  = done_v[sel];
    m_cclk  = cclk_v[sel];
    m_crst  = crst_v[sel];
    m_cin   = cin_v[sel];
  end

  cfg_chain_loader #(.WORD_W(W), .CHAIN_LEN(37), .RST_CYC(RST)) u_dut37 (
    .clk(clk), .reset(reset), .start(start_v[0]), .abort(abort_v[0]),
    .word_in(word_in), .word_valid(valid_v[0]), .word_ready(ready_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .config_clk(cclk_v[0]),
    .config_reset(crst_v[0]), .config_in(cin_v[0]));

  cfg_chain_loader #(.WORD_W(W), .CHAIN_LEN(64), .RST_CYC(RST)) u_dut64 (
    .clk(clk), .reset(reset), .start(start_v[1]), .abort(abort_v[1]),
    .word_in(word_in), .word_valid(valid_v[1]), .word_ready(ready_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .config_clk(cclk_v[1]),
    .config_reset(crst_v[1]), .config_in(cin_v[1]));

  cfg_chain_loader #(.WORD_W(W), .CHAIN_LEN(32), .RST_CYC(RST)) u_dut32 (
    .clk(clk), .reset(reset), .start(start_v[2]), .abort(abort_v[2]),
    .word_in(word_in), .word_valid(valid_v[2]), .word_ready(ready_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .config_clk(cclk_v[2]),
    .config_reset(crst_v[2]), .config_in(cin_v[2]));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Observed chain behaviour, accumulated once per clk after the edge.
  logic         captured[$];
  logic [W-1:0] feed_q[$];
  logic [W-1:0] load_words[$];
  logic [W-1:0] sent[$];
  int  edges, viol, overlap, dones, hs_cnt, crst_cyc, busy_drop;
  int  cyc, rst_fall, first_edge, stall_cfg, stall_left;
  bit  prev_clk, prev_in, prev_crst, in_load;

  function automatic int len_of(input logic [1:0] s);
    case (s)
      2'd0:    return 37;
      2'd1:    return 64;
      default: return 32;
    endcase
  endfunction

  task automatic mon_clear();
    captured.delete();
    edges = 0; viol = 0; overlap = 0; dones = 0; hs_cnt = 0;
    crst_cyc = 0; busy_drop = 0; cyc = 0; rst_fall = -1; first_edge = -1;
    prev_clk = 1'b0; prev_in = 1'b0; prev_crst = 1'b0;
  endtask

  task automatic tick();
    bit hs;
    hs = word_valid && m_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (hs) begin
      hs_cnt++;
      void'(feed_q.pop_front());
      stall_left = stall_cfg;
    end else if (m_ready && stall_left > 0) begin
      stall_left--;
    end
    if (m_cclk && !prev_clk) begin
      edges++;
      captured.push_back(m_cin);
      if (first_edge < 0) first_edge = cyc;
    end
    if (m_cclk && (m_cin != prev_in)) viol++;
    if (m_ready && m_cclk) overlap++;
    if (m_done) dones++;
    if (m_crst) crst_cyc++;
    if (!m_crst && prev_crst) rst_fall = cyc;
    if (in_load && !m_busy && !m_done) busy_drop++;
    prev_clk  = m_cclk;
    prev_in   = m_cin;
    prev_crst = m_crst;
    word_valid = (feed_q.size() > 0) && (stall_left == 0);
    word_in    = (feed_q.size() > 0) ? feed_q[0] : '0;
  endtask

  task automatic begin_load(input logic [1:0] s, input int stall);
    mon_clear();
    sel        = s;
    feed_q     = load_words;
    sent       = load_words;
    stall_cfg  = stall;
    stall_left = 0;
    word_valid = (feed_q.size() > 0);
    word_in    = (feed_q.size() > 0) ? feed_q[0] : '0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Expected chain contents: the words concatenated LSB-first, truncated to the chain.
  function automatic int bit_mismatches();
    int m = 0;
    for (int k = 0; k < captured.size(); k++) begin
      if (k / W >= sent.size()) m++;
      else if (captured[k] != sent[k / W][k % W]) m++;
    end
    return m;
  endfunction

  task automatic run_load(input string tag, input logic [1:0] s, input int stall,
                          input int poke, input int exp_edges, input int exp_words);
    int n;
    bit poked;
    begin_load(s, stall);
    in_load = 1'b1;
    n = 0;
    poked = 1'b0;
    while (!m_done && n < 3000) begin
      if (poke >= 0 && edges == poke && !poked) begin
        start = 1'b1;
        poked = 1'b1;
      end
      tick();
      start = 1'b0;
      n++;
    end
    in_load = 1'b0;
    check({tag, "_timeout"}, int'(n >= 3000), 0);
    repeat (4) tick();
    check({tag, "_edges"},     edges, exp_edges);
    check({tag, "_words"},     hs_cnt, exp_words);
    check({tag, "_done"},      dones, 1);
    check({tag, "_bits"},      bit_mismatches(), 0);
    check({tag, "_stable"},    viol, 0);
    check({tag, "_rdy_clk"},   overlap, 0);
    check({tag, "_busy"},      busy_drop, 0);
    check({tag, "_clr_cyc"},   crst_cyc, RST);
    check({tag, "_clr_gap"},   int'(first_edge - rst_fall >= 2), 1);
    feed_q.delete();
    word_valid = 1'b0;
  endtask

  typedef struct {
    logic [1:0]   sel;
    logic [W-1:0] w0, w1, w2;
    int           nw;
    int           stall;
    int           exp_edges;
    int           exp_words;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n;
    logic [1:0] s;
    vecs[0] = '{2'd0, 32'hA5A5A5A5, 32'h0000001F, 32'hDEADBEEF, 3, 0,  37, 2};
    vecs[1] = '{2'd0, 32'hA5A5A5A5, 32'h0000001F, 32'hDEADBEEF, 3, 10, 37, 2};
    vecs[2] = '{2'd1, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 3, 3,  64, 2};
    vecs[3] = '{2'd2, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 2, 0,  32, 1};

    reset = 1'b1; start = 1'b0; abort = 1'b0; word_valid = 1'b0;
    word_in = '0; sel = 2'd0; in_load = 1'b0; stall_cfg = 0; stall_left = 0;
    mon_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_outs", int'({ready_v, busy_v, done_v, cclk_v, crst_v, cin_v}), 0);

    for (int i = 0; i < 4; i++) begin
      load_words.delete();
      load_words.push_back(vecs[i].w0);
      if (vecs[i].nw > 1) load_words.push_back(vecs[i].w1);
      if (vecs[i].nw > 2) load_words.push_back(vecs[i].w2);
      run_load($sformatf("vec%0d", i), vecs[i].sel, vecs[i].stall, -1,
               vecs[i].exp_edges, vecs[i].exp_words);
    end

    // Abort after 20 edges, then a full reload from a fresh clear.
    load_words.delete();
    repeat (3) load_words.push_back($urandom);
    begin_load(2'd1, 0);
    n = 0;
    while (edges < 20 && n < 500) begin
      tick();
      n++;
    end
    check("abort_reach20", edges, 20);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle_outs", int'({m_busy, m_cclk, m_crst, m_ready, m_done}), 0);
    repeat (4) tick();
    check("abort_no_done", dones, 0);
    check("abort_no_edges", edges, 20);
    feed_q.delete();
    word_valid = 1'b0;
    run_load("reload", 2'd1, 0, -1, 64, 2);

    // Reset while config_clk is high.
    load_words.delete();
    repeat (3) load_words.push_back($urandom);
    begin_load(2'd0, 0);
    n = 0;
    while (!m_cclk && n < 200) begin
      tick();
      n++;
    end
    check("rst_reach_phase_b", int'(m_cclk), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_outs", int'({ready_v, busy_v, done_v, cclk_v, crst_v, cin_v}), 0);
    feed_q.delete();
    word_valid = 1'b0;
    tick();

    // start pulsed mid-load must not restart or re-clear.
    load_words.delete();
    load_words.push_back($urandom);
    load_words.push_back($urandom);
    run_load("start_busy", 2'd2, 0, 5, 32, 1);

    // start and abort together in IDLE: start wins; abort in CLR returns to IDLE.
    load_words.delete();
    mon_clear();
    sel = 2'd2;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_wins", int'({m_busy, m_crst}), 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_in_clr", int'({m_busy, m_crst}), 0);
    tick();

    // Randomized loads against the concatenation model.
    for (int r = 0; r < 6; r++) begin
      int len, nw;
      s = 2'($urandom_range(0, 2));
      len = len_of(s);
      nw = (len + W - 1) / W;
      load_words.delete();
      for (int j = 0; j <= nw; j++) load_words.push_back($urandom);
      run_load($sformatf("rnd%0d", r), s, int'($urandom_range(0, 5)), -1, len, nw);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
